// File: rtl/w_req_pkg.sv
// Shared types and helpers for the multi-channel write-request arbiter.
package w_req_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} w_arb_state_t;

  // Index width that stays at least one bit, so a single-channel build still has a grant_id port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr wins, else wraps to 0.
module rr_arbiter
  import w_req_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            vld
);

  always_comb begin
    // NOTE: every output gets a default before the search, so no path leaves one unassigned (no latch).
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (!vld && req[c] && (c >= int'(ptr))) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = ID_W'(c);
      end
    end
    // Second pass only runs when nothing at or above ptr was requesting.
    for (int c = 0; c < N; c++) begin
      if (!vld && req[c]) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/w_req_arb.sv
// Multi-channel write-request arbiter: grants one AW/W FIFO pair at a time, pops its AW head,
// streams len+1 W beats, and (with LOOKAHEAD) re-grants during the last beat for back-to-back bursts.
module w_req_arb
  import w_req_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int LEN_W     = 8,
  parameter int LOOKAHEAD = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             aw_empty,
  input  logic [NUM_CH-1:0]             aw_al_empty,
  input  logic [NUM_CH-1:0]             w_empty,
  input  logic [NUM_CH-1:0]             w_al_empty,
  input  logic [NUM_CH*LEN_W-1:0]       aw_len,
  input  logic                          b_full,
  input  logic                          b_al_full,
  input  logic                          w_ready,
  output logic [NUM_CH-1:0]             w_req,
  output logic                          grant_vld,
  output logic [clog2_min1(NUM_CH)-1:0] grant_id,
  output logic [NUM_CH-1:0]             aw_pop,
  output logic [NUM_CH-1:0]             w_pop,
  output logic                          w_last,
  output logic [LEN_W-1:0]              beat_cnt
);

  localparam int ID_W = clog2_min1(NUM_CH);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CH - 1);

  w_arb_state_t      state, state_nxt;
  logic [ID_W-1:0]   grant_nxt, ptr, ptr_nxt, ptr_after, arb_ptr, arb_idx;
  logic [NUM_CH-1:0] grant_oh, oh_nxt, arb_gnt;
  logic              arb_vld;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_arr [NUM_CH];
  logic              in_data, pop_any, at_last, last_pop, look;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_len
    assign len_arr[i] = aw_len[i*LEN_W +: LEN_W];
  end

  assign in_data   = (state == DATA);
  assign pop_any   = in_data & w_ready & ~w_empty[grant_id];
  assign at_last   = (beat_cnt == len);
  assign last_pop  = pop_any & at_last;
  assign look      = (LOOKAHEAD != 0) && last_pop;
  assign ptr_after = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
  // During a last beat the next search already starts past the releasing channel.
  assign arb_ptr   = in_data ? ptr_after : ptr;

  assign grant_vld = (state != IDLE);
  assign w_last    = in_data & at_last;
  assign aw_pop    = (state == ADDR) ? grant_oh : '0;
  assign w_pop     = pop_any ? grant_oh : '0;

  // In lookahead the releasing channel must still hold an entry after this pop, and the B FIFO
  // must keep room for the response of the burst now completing.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (look) begin
        w_req[i] = ~b_al_full & ((i == int'(grant_id)) ? (~aw_al_empty[i] & ~w_al_empty[i])
                                                       : (~aw_empty[i] & ~w_empty[i]));
      end else begin
        w_req[i] = ~aw_empty[i] & ~w_empty[i] & ~b_full;
      end
    end
  end

  rr_arbiter #(.N(NUM_CH), .ID_W(ID_W)) u_rr (
    .req (w_req),
    .ptr (arb_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    oh_nxt    = grant_oh;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (arb_vld) begin
          grant_nxt = arb_idx;
          oh_nxt    = arb_gnt;
          state_nxt = ADDR;
        end
      end
      ADDR: state_nxt = DATA;
      DATA: begin
        if (last_pop) begin
          ptr_nxt = ptr_after;
          if ((LOOKAHEAD != 0) && arb_vld) begin
            grant_nxt = arb_idx;
            oh_nxt    = arb_gnt;
            state_nxt = ADDR;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every register, len included, has an async reset so an aborted burst leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      grant_oh <= '0;
      ptr      <= '0;
      len      <= '0;
      beat_cnt <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      state    <= state_nxt;
      grant_id <= grant_nxt;
      grant_oh <= oh_nxt;
      ptr      <= ptr_nxt;
      if (state == ADDR) begin
        len      <= len_arr[grant_id];
        beat_cnt <= '0;
      end else if (pop_any && !at_last) begin
        // Held on the final beat, so a max-length burst never wraps.
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
    end
  end

endmodule
